// File: rtl/rtc_calendar.sv
// rtc_calendar: BCD calendar stage downstream of the RTC time-of-day counter.
// Advances year/month/day and weekday on each day-rollover pulse, applies month
// lengths and leap-year rules, and validates software date loads.
//
// Configuration macro: RTC_CALENDAR_CENTURY_RULE_EN
//   defined   -> full Gregorian leap rule (2000 leap, 2100 not leap)
//   undefined -> leap iff low two year digits divisible by 4
//
// Ports:
//   clk_i          system clock
//   rstn_i         synchronous active-low reset
//   new_day_i      one-cycle day-rollover pulse
//   date_update_i  one-cycle load strobe
//   date_i         BCD date to load {YYYY, MM, DD}
//   wday_i         weekday loaded with date_i (0 = Sunday .. 6 = Saturday)
//   date_o         current BCD date {YYYY, MM, DD}
//   wday_o         current weekday
//   load_err_o     one-cycle pulse on a rejected load
//   year_wrap_o    one-cycle pulse on 9999-12-31 -> 0000-01-01
module rtc_calendar #(
    parameter logic [31:0] RST_DATE = 32'h2000_0101,
    parameter logic [2:0]  RST_WDAY = 3'd6
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        new_day_i,
    input  logic        date_update_i,
    input  logic [31:0] date_i,
    input  logic [2:0]  wday_i,
    output logic [31:0] date_o,
    output logic [2:0]  wday_o,
    output logic        load_err_o,
    output logic        year_wrap_o
);

    localparam int unsigned NIBBLES  = 8;
    localparam logic [2:0]  WDAY_MAX = 3'd6;

    // Divisibility by 4 of a two-digit BCD number, done on the digits directly.
    function automatic logic div4_bcd(input logic [7:0] v);
        if (v[4]) begin
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        end
        return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    // Month length as a BCD day count.
    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return leap ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    // Two-digit BCD increment; 99 wraps to 00 so it can chain into a carry.
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v == 8'h99) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {4'(v[7:4] + 4'd1), 4'h0};
        end
        return {v[7:4], 4'(v[3:0] + 4'd1)};
    endfunction

    function automatic logic nibbles_ok(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    logic [15:0] year_q;
    logic [7:0]  month_q;
    logic [7:0]  day_q;
    logic [2:0]  wday_q;
    logic        load_err_q;
    logic        year_wrap_q;

    logic [15:0] year_d;
    logic [7:0]  month_d;
    logic [7:0]  day_d;
    logic [2:0]  wday_d;
    logic        load_err_d;
    logic        year_wrap_d;

    logic        cur_leap;
    logic        ld_leap;
    logic [7:0]  cur_dim;
    logic [7:0]  ld_dim;
    logic        ld_valid;
    logic [15:0] year_inc;

    // Leap flags for the current year and for the year being loaded.
`ifdef RTC_CALENDAR_CENTURY_RULE_EN
    assign cur_leap = (year_q[7:0] == 8'h00) ? div4_bcd(year_q[15:8]) : div4_bcd(year_q[7:0]);
    assign ld_leap  = (date_i[23:16] == 8'h00) ? div4_bcd(date_i[31:24]) : div4_bcd(date_i[23:16]);
`else
    assign cur_leap = div4_bcd(year_q[7:0]);
    assign ld_leap  = div4_bcd(date_i[23:16]);
`endif

    assign cur_dim = days_in_month(month_q, cur_leap);
    assign ld_dim  = days_in_month(date_i[15:8], ld_leap);

    // Once every nibble is a decimal digit, packed BCD compares like binary.
    assign ld_valid = nibbles_ok(date_i)
                   && (date_i[15:8] >= 8'h01) && (date_i[15:8] <= 8'h12)
                   && (date_i[7:0]  >= 8'h01) && (date_i[7:0]  <= ld_dim)
                   && (wday_i <= WDAY_MAX);

    // Four-digit BCD year increment with carry from the low pair to the high pair.
    assign year_inc = {(year_q[7:0] == 8'h99) ? bcd_inc8(year_q[15:8]) : year_q[15:8],
                       bcd_inc8(year_q[7:0])};

    // Next-state: a load wins over a day increment in the same cycle.
    always_comb begin
        year_d      = year_q;
        month_d     = month_q;
        day_d       = day_q;
        wday_d      = wday_q;
        load_err_d  = 1'b0;
        year_wrap_d = 1'b0;
        if (date_update_i) begin
            if (ld_valid) begin
                year_d  = date_i[31:16];
                month_d = date_i[15:8];
                day_d   = date_i[7:0];
                wday_d  = wday_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (new_day_i) begin
            wday_d = (wday_q >= WDAY_MAX) ? 3'd0 : 3'(wday_q + 3'd1);
            if (day_q < cur_dim) begin
                day_d = bcd_inc8(day_q);
            end else begin
                day_d = 8'h01;
                if (month_q == 8'h12) begin
                    month_d     = 8'h01;
                    year_d      = year_inc;
                    year_wrap_d = (year_q == 16'h9999);
                end else begin
                    month_d = bcd_inc8(month_q);
                end
            end
        end
    end

    // State and output registers; reset discards any pending pulse.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            year_q      <= RST_DATE[31:16];
            month_q     <= RST_DATE[15:8];
            day_q       <= RST_DATE[7:0];
            wday_q      <= RST_WDAY;
            load_err_q  <= 1'b0;
            year_wrap_q <= 1'b0;
        end else begin
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            wday_q      <= wday_d;
            load_err_q  <= load_err_d;
            year_wrap_q <= year_wrap_d;
        end
    end

    assign date_o      = {year_q, month_q, day_q};
    assign wday_o      = wday_q;
    assign load_err_o  = load_err_q;
    assign year_wrap_o = year_wrap_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Testbench for rtc_calendar: directed scenarios plus randomized traffic checked
// against an integer-arithmetic calendar model.
module tb_rtc_calendar;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        new_day_i;
    logic        date_update_i;
    logic [31:0] date_i;
    logic [2:0]  wday_i;
    logic [31:0] date_o;
    logic [2:0]  wday_o;
    logic        load_err_o;
    logic        year_wrap_o;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers.
    int m_y, m_m, m_d, m_w;
    bit m_err, m_wrap;

    rtc_calendar dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .new_day_i     (new_day_i),
        .date_update_i (date_update_i),
        .date_i        (date_i),
        .wday_i        (wday_i),
        .date_o        (date_o),
        .wday_o        (wday_o),
        .load_err_o    (load_err_o),
        .year_wrap_o   (year_wrap_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit is_leap(int y);
`ifdef RTC_CALENDAR_CENTURY_RULE_EN
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
        return (y % 4 == 0);
`endif
    endfunction

    function automatic int dim(int y, int m);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return is_leap(y) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(int y, int m, int d);
        return {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10),
                4'(m / 10), 4'(m % 10), 4'(d / 10), 4'(d % 10)};
    endfunction

    function automatic int dig(logic [31:0] v, int i);
        return int'(v[4*i +: 4]);
    endfunction

    task automatic model_apply(input logic rst_n, input logic upd, input logic [31:0] d,
                               input logic [2:0] w, input logic nd);
        bit ok;
        int yy, mm, dd;
        m_err  = 0;
        m_wrap = 0;
        if (!rst_n) begin
            m_y = 2000; m_m = 1; m_d = 1; m_w = 6;
        end else if (upd) begin
            ok = 1;
            for (int i = 0; i < 8; i++) if (dig(d, i) > 9) ok = 0;
            yy = dig(d, 7) * 1000 + dig(d, 6) * 100 + dig(d, 5) * 10 + dig(d, 4);
            mm = dig(d, 3) * 10 + dig(d, 2);
            dd = dig(d, 1) * 10 + dig(d, 0);
            if (ok) ok = (mm >= 1) && (mm <= 12);
            if (ok) ok = (dd >= 1) && (dd <= dim(yy, mm));
            if (ok) ok = (int'(w) <= 6);
            if (ok) begin
                m_y = yy; m_m = mm; m_d = dd; m_w = int'(w);
            end else begin
                m_err = 1;
            end
        end else if (nd) begin
            m_w = (m_w + 1) % 7;
            m_d++;
            if (m_d > dim(m_y, m_m)) begin
                m_d = 1;
                m_m++;
                if (m_m > 12) begin
                    m_m = 1;
                    m_y++;
                    if (m_y > 9999) begin
                        m_y = 0;
                        m_wrap = 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input logic rst_n, input logic upd, input logic [31:0] d,
                        input logic [2:0] w, input logic nd);
        rstn_i        = rst_n;
        date_update_i = upd;
        date_i        = d;
        wday_i        = w;
        new_day_i     = nd;
        @(posedge clk_i);
        model_apply(rst_n, upd, d, w, nd);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
        step(1'b0, 1'b1, 32'h2024_0505, 3'd2, 1'b0);
        rstn_i = 1'b1; date_update_i = 1'b0; new_day_i = 1'b0;
        total++; if (date_o !== 32'h2000_0101) begin bad++; $display("FAIL reset_date got=%h exp=%h", date_o, 32'h2000_0101); end
        total++; if (wday_o !== 3'd6) begin bad++; $display("FAIL reset_wday got=%0d exp=6", wday_o); end
        total++; if (load_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", load_err_o); end
        total++; if (year_wrap_o !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", year_wrap_o); end
    endtask

    task automatic test_leap_feb();
        step(1'b1, 1'b1, 32'h2024_0228, 3'd3, 1'b0);
        total++; if (date_o !== 32'h2024_0228 || wday_o !== 3'd3) begin bad++; $display("FAIL leap_load got=%h/%0d exp=20240228/3", date_o, wday_o); end
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
        total++; if (date_o !== 32'h2024_0229 || wday_o !== 3'd4) begin bad++; $display("FAIL leap_0229 got=%h/%0d exp=20240229/4", date_o, wday_o); end
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
        total++; if (date_o !== 32'h2024_0301 || wday_o !== 3'd5) begin bad++; $display("FAIL leap_0301 got=%h/%0d exp=20240301/5", date_o, wday_o); end
    endtask

    task automatic test_year_wrap();
        step(1'b1, 1'b1, 32'h9999_1231, 3'd5, 1'b0);
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
        total++; if (date_o !== 32'h0000_0101 || wday_o !== 3'd6) begin bad++; $display("FAIL wrap_date got=%h/%0d exp=00000101/6", date_o, wday_o); end
        total++; if (year_wrap_o !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%b exp=1", year_wrap_o); end
        idle();
        total++; if (year_wrap_o !== 1'b0 || date_o !== 32'h0000_0101) begin bad++; $display("FAIL wrap_one_cycle got=%b/%h exp=0/00000101", year_wrap_o, date_o); end
        step(1'b1, 1'b1, 32'h1999_1231, 3'd5, 1'b0);
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
        total++; if (date_o !== 32'h2000_0101 || year_wrap_o !== 1'b0) begin bad++; $display("FAIL y2k got=%h/%b exp=20000101/0", date_o, year_wrap_o); end
    endtask

    task automatic test_century();
        logic [31:0] exp_inc;
        logic [31:0] exp_after;
        logic        exp_err;
`ifdef RTC_CALENDAR_CENTURY_RULE_EN
        exp_inc = 32'h2100_0301; exp_after = 32'h2100_0301; exp_err = 1'b1;
`else
        exp_inc = 32'h2100_0229; exp_after = 32'h2100_0229; exp_err = 1'b0;
`endif
        step(1'b1, 1'b1, 32'h2100_0228, 3'd0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
        total++; if (date_o !== exp_inc) begin bad++; $display("FAIL century_inc got=%h exp=%h", date_o, exp_inc); end
        step(1'b1, 1'b1, 32'h2100_0229, 3'd1, 1'b0);
        total++; if (load_err_o !== exp_err || date_o !== exp_after) begin bad++; $display("FAIL century_load got=%b/%h exp=%b/%h", load_err_o, date_o, exp_err, exp_after); end
    endtask

    task automatic test_invalid_loads();
        logic [31:0] bad_dates [5];
        bad_dates[0] = 32'h2023_0229;
        bad_dates[1] = 32'h2024_1301;
        bad_dates[2] = 32'h2024_0431;
        bad_dates[3] = 32'h2024_011A;
        bad_dates[4] = 32'h2024_0100;
        step(1'b1, 1'b1, 32'h2024_0115, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, bad_dates[i], 3'd2, 1'b0);
            total++; if (load_err_o !== 1'b1 || date_o !== 32'h2024_0115 || wday_o !== 3'd1) begin bad++; $display("FAIL invalid_%0d got=%b/%h/%0d exp=1/20240115/1", i, load_err_o, date_o, wday_o); end
        end
        step(1'b1, 1'b1, 32'h2024_0116, 3'd7, 1'b0);
        total++; if (load_err_o !== 1'b1 || date_o !== 32'h2024_0115) begin bad++; $display("FAIL invalid_wday got=%b/%h exp=1/20240115", load_err_o, date_o); end
        idle();
        total++; if (load_err_o !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b exp=0", load_err_o); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 32'h2024_0115, 3'd1, 1'b1);
        total++; if (date_o !== 32'h2024_0115 || wday_o !== 3'd1) begin bad++; $display("FAIL simul got=%h/%0d exp=20240115/1", date_o, wday_o); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
        total++; if (date_o !== 32'h2024_0118 || wday_o !== 3'd4) begin bad++; $display("FAIL b2b got=%h/%0d exp=20240118/4", date_o, wday_o); end
    endtask

    task automatic test_reset_midop();
        step(1'b1, 1'b1, 32'h9999_1231, 3'd3, 1'b0);
        step(1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
        total++; if (date_o !== 32'h2000_0101 || wday_o !== 3'd6 || year_wrap_o !== 1'b0) begin bad++; $display("FAIL midop_reset got=%h/%0d/%b exp=20000101/6/0", date_o, wday_o, year_wrap_o); end
    endtask

    task automatic test_random();
        int kind, y, m, d;
        logic [31:0] ld;
        logic [2:0]  w;
        logic        upd, nd;
        for (int n = 0; n < 1500; n++) begin
            kind = int'($urandom_range(0, 99));
            upd  = (kind < 12);
            nd   = ($urandom_range(0, 99) < 70);
            y = int'($urandom_range(0, 9999));
            case ($urandom_range(0, 4))
                0: y = 9999;
                1: y = 2100;
                2: y = 2000;
                default: ;
            endcase
            m  = int'($urandom_range(1, 12));
            d  = ($urandom_range(0, 1) == 0) ? dim(y, m) : int'($urandom_range(1, dim(y, m)));
            w  = 3'($urandom_range(0, 6));
            ld = to_bcd(y, m, d);
            if (kind < 3) ld = $urandom();
            else if (kind < 5) ld = to_bcd(y, m, dim(y, m) + 1);
            else if (kind < 6) w = 3'd7;
            step(1'b1, upd, ld, w, nd);
            total++; if (date_o !== to_bcd(m_y, m_m, m_d)) begin bad++; $display("FAIL rnd_date n=%0d got=%h exp=%h", n, date_o, to_bcd(m_y, m_m, m_d)); end
            total++; if (wday_o !== 3'(m_w)) begin bad++; $display("FAIL rnd_wday n=%0d got=%0d exp=%0d", n, wday_o, m_w); end
            total++; if (load_err_o !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, load_err_o, m_err); end
            total++; if (year_wrap_o !== m_wrap) begin bad++; $display("FAIL rnd_wrap n=%0d got=%b exp=%b", n, year_wrap_o, m_wrap); end
        end
    endtask

    initial begin
        rstn_i = 1'b0; new_day_i = 1'b0; date_update_i = 1'b0; date_i = 32'h0; wday_i = 3'd0;
        test_reset();
        test_leap_feb();
        test_year_wrap();
        test_century();
        test_invalid_loads();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
